// File: rtl/dsc_pkg.sv
// Shared types and helpers for the deterministic stochastic-computing datapath.
package dsc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Length of one unary stream period for a given operand width.
   function automatic int unsigned stream_len(input int unsigned width);
      return 32'd1 << width;
   endfunction

endpackage

// File: rtl/dsc_ramp_sng.sv
// Ramp-compare stream generator: operand register, ramp counter with enable,
// wrap flag and comparator bit (operand > ramp).
module dsc_ramp_sng
   import dsc_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] operand,
   output logic             wrap,
   output logic             sbit
);

   localparam logic [WIDTH-1:0] CTR_MAX = WIDTH'(stream_len(WIDTH) - 32'd1);

   logic [WIDTH-1:0] val;
   logic [WIDTH-1:0] ctr;

   // Load latches the operand and restarts the ramp; the counter wraps naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         val <= '0;
         ctr <= '0;
      end else if (load) begin
         val <= operand;
         ctr <= '0;
      end else if (en) begin
         ctr <= ctr + WIDTH'(1);
      end
   end

   assign wrap = (ctr == CTR_MAX);
   assign sbit = (val > ctr);

endmodule

// File: rtl/dsc_mul_seq.sv
// Sequential DSC multiplier: ANDs two ramp-compared unary streams and counts the ones.
// Optional macro DSC_MUL_SEQ_EARLY_STOP_EN ends the run once stream B has gone to zero.
module dsc_mul_seq
   import dsc_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] z,
   output logic               sn_y
);

   localparam int unsigned ZW = 2 * WIDTH;

   state_t state;
   state_t next_state;

   logic accept;
   logic run;
   logic wrap_a;
   logic wrap_b;
   logic a_bit;
   logic b_bit;
   logic last;

   assign accept = (state == IDLE) && start;
   assign run    = (state == RUN);

   dsc_ramp_sng #(.WIDTH(WIDTH)) u_sng_a (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .en      (run),
      .operand (a),
      .wrap    (wrap_a),
      .sbit    (a_bit)
   );

   // Stream B steps once per full period of stream A.
   dsc_ramp_sng #(.WIDTH(WIDTH)) u_sng_b (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .en      (run & wrap_a),
      .operand (b),
      .wrap    (wrap_b),
      .sbit    (b_bit)
   );

`ifdef DSC_MUL_SEQ_EARLY_STOP_EN
   // Once B's ramp reaches b, its stream stays zero and no more ones can accrue.
   assign last = ~b_bit;
`else
   assign last = wrap_a & wrap_b;
`endif

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (last)  next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= (next_state == RUN);
         done  <= (next_state == DONE);
      end
   end

   // Product accumulator; cleared on accept and held until the next accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         z <= '0;
      end else if (accept) begin
         z <= '0;
      end else if (run) begin
         z <= z + ZW'(a_bit & b_bit);
      end
   end

   assign sn_y = run & a_bit & b_bit;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Directed self-checking bench for dsc_mul_seq at WIDTH=4 and WIDTH=8.
module tb_dsc_mul_seq;

   logic clk;
   logic rst;

   logic       start4, busy4, done4, sn_y4;
   logic [3:0] a4, b4;
   logic [7:0] z4;

   logic        start8, busy8, done8, sn_y8;
   logic [7:0]  a8, b8;
   logic [15:0] z8;

   int checks = 0;
   int errors = 0;

`ifdef DSC_MUL_SEQ_EARLY_STOP_EN
   localparam int LEN_5_3   = 49;
   localparam int LEN_15_15 = 241;
   localparam int LEN_9_0   = 1;
   localparam int LEN_0_7   = 113;
   localparam int LEN_6_6   = 97;
   localparam int LEN_W8    = 65281;
   localparam int ABORT_CYC = 40;
`else
   localparam int LEN_5_3   = 256;
   localparam int LEN_15_15 = 256;
   localparam int LEN_9_0   = 256;
   localparam int LEN_0_7   = 256;
   localparam int LEN_6_6   = 256;
   localparam int LEN_W8    = 65536;
   localparam int ABORT_CYC = 100;
`endif

   dsc_mul_seq #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst   (rst),
      .start (start4),
      .a     (a4),
      .b     (b4),
      .busy  (busy4),
      .done  (done4),
      .z     (z4),
      .sn_y  (sn_y4)
   );

   dsc_mul_seq #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .busy  (busy8),
      .done  (done8),
      .z     (z8),
      .sn_y  (sn_y8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One operation on the selected instance; inj injects a stray start mid-run,
   // abort pulses reset at that RUN cycle (negative disables either).
   task automatic run_op(input bit w8, input string tag, input int av, input int bv,
                         input int exp_z, input int exp_len, input int inj, input int abort);
      int  cyc;
      int  ones;
      bit  aborted;
      cyc     = 0;
      ones    = 0;
      aborted = 1'b0;
      @(negedge clk);
      if (w8) begin a8 = 8'(av); b8 = 8'(bv); start8 = 1'b1; end
      else    begin a4 = 4'(av); b4 = 4'(bv); start4 = 1'b1; end
      @(negedge clk);
      start4 = 1'b0;
      start8 = 1'b0;
      a4 = 4'd0; b4 = 4'd0; a8 = 8'd0; b8 = 8'd0;
      while ((w8 ? busy8 : busy4) && cyc < 70000) begin
         if (cyc == inj) begin start4 = 1'b1; a4 = 4'd2; b4 = 4'd2; end
         if (cyc == inj + 10) start4 = 1'b0;
         if (cyc == abort) begin
            rst = 1'b0;
            #1;
            check({tag, "_rst_busy"}, 32'(busy4), 32'd0);
            check({tag, "_rst_done"}, 32'(done4), 32'd0);
            check({tag, "_rst_z"},    32'(z4),    32'd0);
            check({tag, "_rst_sn_y"}, 32'(sn_y4), 32'd0);
            aborted = 1'b1;
            break;
         end
         ones += int'(w8 ? sn_y8 : sn_y4);
         cyc++;
         @(negedge clk);
      end
      start4 = 1'b0;
      if (aborted) begin
         @(negedge clk);
         rst = 1'b1;
         return;
      end
      check({tag, "_done"},  32'(w8 ? done8 : done4), 32'd1);
      check({tag, "_z"},     w8 ? 32'(z8) : 32'(z4), 32'(exp_z));
      check({tag, "_len"},   32'(cyc),  32'(exp_len));
      check({tag, "_ones"},  32'(ones), 32'(exp_z));
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(w8 ? done8 : done4), 32'd0);
      check({tag, "_idle_busy"},  32'(w8 ? busy8 : busy4), 32'd0);
      check({tag, "_z_hold"},     w8 ? 32'(z8) : 32'(z4), 32'(exp_z));
   endtask

   initial begin
      rst = 1'b0;
      start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
      start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy4), 32'd0);
      check("reset_done", 32'(done4), 32'd0);
      check("reset_z",    32'(z4),    32'd0);
      check("reset_sn_y", 32'(sn_y4), 32'd0);
      check("reset_z8",   32'(z8),    32'd0);
      rst = 1'b1;
      @(negedge clk);

      run_op(1'b0, "a5b3",   5,  3,  15, LEN_5_3,   -1, -1);
      run_op(1'b0, "a15b15", 15, 15, 225, LEN_15_15, -1, -1);
      run_op(1'b0, "a9b0",   9,  0,  0,  LEN_9_0,   -1, -1);
      run_op(1'b0, "a0b7",   0,  7,  0,  LEN_0_7,   20, -1);
      run_op(1'b0, "a6b6abort", 6, 6, 36, LEN_6_6,  -1, ABORT_CYC);
      run_op(1'b0, "a6b6",   6,  6,  36, LEN_6_6,   -1, -1);
      run_op(1'b1, "w8",     255, 255, 65025, LEN_W8, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
